// File: rtl/basic_bus_arb.sv
// ============================================================================
// Module   : basic_bus_arb
// Brief    : Two-master round-robin arbiter onto a single basic bus.
//            Each access has a programmable number of read wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module basic_bus_arb #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic        m0_rd,
  input  logic [20:0] m0_addr,
  input  logic [31:0] m0_wr_data,
  output logic [31:0] m0_rd_data,
  output logic        m0_ready,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic        m1_rd,
  input  logic [20:0] m1_addr,
  input  logic [31:0] m1_wr_data,
  output logic [31:0] m1_rd_data,
  output logic        m1_ready,
  output logic        b_cs,
  output logic        b_wr,
  output logic        b_rd,
  output logic [20:0] b_addr,
  output logic [31:0] b_wr_data,
  input  logic [31:0] b_rd_data
);

  localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wait_cnt;
  logic        last_m1;
  logic        gnt_m1;
  logic        rd_xfer;

  logic        any_req;
  logic        sel_m1;
  logic        sel_wr;
  logic        sel_rd;
  logic [20:0] sel_addr;
  logic [31:0] sel_wr_data;

  // Round-robin: on a tie the master that was not served last wins.
  always_comb begin
    any_req     = m0_req | m1_req;
    sel_m1      = m1_req & (~m0_req | ~last_m1);
    sel_wr      = m0_wr;
    sel_rd      = m0_rd;
    sel_addr    = m0_addr;
    sel_wr_data = m0_wr_data;
    if (sel_m1) begin
      sel_wr      = m1_wr;
      sel_rd      = m1_rd;
      sel_addr    = m1_addr;
      sel_wr_data = m1_wr_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = WAIT;
      WAIT:    if (wait_cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt   <= 4'd0;
      last_m1    <= 1'b1;
      gnt_m1     <= 1'b0;
      rd_xfer    <= 1'b0;
      b_cs       <= 1'b0;
      b_wr       <= 1'b0;
      b_rd       <= 1'b0;
      b_addr     <= 21'd0;
      b_wr_data  <= 32'd0;
      m0_rd_data <= 32'd0;
      m1_rd_data <= 32'd0;
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_m1    <= sel_m1;
            rd_xfer   <= sel_rd & ~sel_wr;
            b_cs      <= 1'b1;
            b_wr      <= sel_wr;
            b_rd      <= sel_rd & ~sel_wr;
            b_addr    <= sel_addr;
            b_wr_data <= sel_wr_data;
          end
        end
        ACCESS: begin
          b_wr     <= 1'b0;
          b_rd     <= 1'b0;
          wait_cnt <= WAIT_INIT;
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            b_cs <= 1'b0;
            if (rd_xfer && !gnt_m1) m0_rd_data <= b_rd_data;
            if (rd_xfer &&  gnt_m1) m1_rd_data <= b_rd_data;
            m0_ready <= ~gnt_m1;
            m1_ready <= gnt_m1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          last_m1  <= gnt_m1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_basic_bus_arb.sv
// ============================================================================
// Module   : tb_basic_bus_arb
// Brief    : Random-stimulus bench for basic_bus_arb at RD_LAT 1 and 4,
//            checked against a transaction-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_basic_bus_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m0_rd, m1_req, m1_wr, m1_rd;
  logic [20:0] m0_addr, m1_addr;
  logic [31:0] m0_wr_data, m1_wr_data, b_rd_data;

  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        cs [2];
  logic        bwr [2];
  logic        brd [2];
  logic [20:0] baddr [2];
  logic [31:0] bwd [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  basic_bus_arb #(.RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr),
    .m0_wr_data(m0_wr_data), .m0_rd_data(rd0[0]), .m0_ready(rdy0[0]),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr),
    .m1_wr_data(m1_wr_data), .m1_rd_data(rd1[0]), .m1_ready(rdy1[0]),
    .b_cs(cs[0]), .b_wr(bwr[0]), .b_rd(brd[0]), .b_addr(baddr[0]),
    .b_wr_data(bwd[0]), .b_rd_data(b_rd_data)
  );

  basic_bus_arb #(.RD_LAT(4)) u_lat4 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr),
    .m0_wr_data(m0_wr_data), .m0_rd_data(rd0[1]), .m0_ready(rdy0[1]),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr),
    .m1_wr_data(m1_wr_data), .m1_rd_data(rd1[1]), .m1_ready(rdy1[1]),
    .b_cs(cs[1]), .b_wr(bwr[1]), .b_rd(brd[1]), .b_addr(baddr[1]),
    .b_wr_data(bwd[1]), .b_rd_data(b_rd_data)
  );

  // Reference: a transaction is a timeline indexed by cycles since its grant.
  int          lat [2] = '{1, 4};
  bit          busy [2];
  int          k [2];
  int          g [2];
  int          last [2];
  bit          t_wr [2];
  bit          t_rd [2];
  logic [20:0] t_addr [2];
  logic [31:0] t_wd [2];
  logic [31:0] e_rd [2][2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      busy[d] = 0; k[d] = 0; g[d] = 0; last[d] = 1;
      t_wr[d] = 0; t_rd[d] = 0; t_addr[d] = '0; t_wd[d] = '0;
      e_rd[d][0] = '0; e_rd[d][1] = '0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (busy[d]) begin
        if (k[d] == 1 + lat[d] && t_rd[d] && !t_wr[d]) e_rd[d][g[d]] = b_rd_data;
        if (k[d] == 2 + lat[d]) begin
          busy[d] = 0;
          last[d] = g[d];
        end else begin
          k[d]++;
        end
      end else if (m0_req || m1_req) begin
        if (m0_req && m1_req) g[d] = (last[d] == 1) ? 0 : 1;
        else                  g[d] = m1_req ? 1 : 0;
        t_wr[d]   = (g[d] == 1) ? m1_wr : m0_wr;
        t_rd[d]   = (g[d] == 1) ? m1_rd : m0_rd;
        t_addr[d] = (g[d] == 1) ? m1_addr : m0_addr;
        t_wd[d]   = (g[d] == 1) ? m1_wr_data : m0_wr_data;
        busy[d]   = 1;
        k[d]      = 1;
      end
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      bit    acc, cs_e, done;
      string p;
      p    = $sformatf("L%0d", lat[d]);
      acc  = busy[d] && k[d] == 1;
      cs_e = busy[d] && k[d] >= 1 && k[d] <= 1 + lat[d];
      done = busy[d] && k[d] == 2 + lat[d];
      check({p, " b_cs"},      64'(cs[d]),    64'(cs_e));
      check({p, " b_wr"},      64'(bwr[d]),   64'(acc && t_wr[d]));
      check({p, " b_rd"},      64'(brd[d]),   64'(acc && t_rd[d] && !t_wr[d]));
      check({p, " b_addr"},    64'(baddr[d]), 64'(t_addr[d]));
      check({p, " b_wr_data"}, 64'(bwd[d]),   64'(t_wd[d]));
      check({p, " m0_ready"},  64'(rdy0[d]),  64'(done && g[d] == 0));
      check({p, " m1_ready"},  64'(rdy1[d]),  64'(done && g[d] == 1));
      check({p, " m0_rd_data"}, 64'(rd0[d]),  64'(e_rd[d][0]));
      check({p, " m1_rd_data"}, 64'(rd1[d]),  64'(e_rd[d][1]));
      check({p, " ready_excl"}, 64'(rdy0[d] & rdy1[d]), 64'd0);
    end
  endtask

  function automatic logic [20:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 21'h000000;
      1:       return 21'h1FFFFF;
      2:       return 21'h000010;
      default: return 21'($urandom);
    endcase
  endfunction

  task automatic drive_random(input bit force_tie);
    m0_req     = force_tie || ($urandom_range(0, 2) != 0);
    m1_req     = force_tie || ($urandom_range(0, 2) != 0);
    m0_wr      = 1'($urandom);
    m0_rd      = 1'($urandom);
    m1_wr      = 1'($urandom);
    m1_rd      = 1'($urandom);
    m0_addr    = pick_addr();
    m1_addr    = pick_addr();
    m0_wr_data = $urandom;
    m1_wr_data = $urandom;
    b_rd_data  = $urandom;
  endtask

  initial begin
    bit rst_done = 0;
    bit tie_next = 0;
    reset = 1'b1;
    m0_req = 0; m0_wr = 0; m0_rd = 0; m0_addr = '0; m0_wr_data = '0;
    m1_req = 0; m1_wr = 0; m1_rd = 0; m1_addr = '0; m1_wr_data = '0;
    b_rd_data = '0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    // First edge after reset is a forced tie: master 0 must win.
    drive_random(1'b1);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
      if (!rst_done && i > 2000 && busy[1] && k[1] >= 2 && k[1] <= 5) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        rst_done = 1;
        tie_next = 1;
      end
      @(negedge clk);
      reset = 1'b0;
      drive_random(tie_next);
      tie_next = 0;
    end
    check("reset_in_wait_hit", 64'(rst_done), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/basic_bus_arb.md
BASIC_BUS_ARB -- requirements
Module: basic_bus_arb

Interface
REQ-001 Parameter RD_LAT, default 1, is the number of wait cycles between the bus strobe and the b_rd_data sample; legal range 1..15.
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, asynchronous active-high reset.
REQ-004 Ports m0_req / m1_req, input, 1 each, master n requests a transaction; held high until mn_ready.
REQ-005 Ports m0_wr, m0_rd / m1_wr, m1_rd, input, 1 each, transaction type qualifiers; valid while req is high.
REQ-006 Ports m0_addr / m1_addr, input, 21 each, word address.
REQ-007 Ports m0_wr_data / m1_wr_data, input, 32 each, write data.
REQ-008 Ports m0_rd_data / m1_rd_data, output, 32 each, registered read data.
REQ-009 Ports m0_ready / m1_ready, output, 1 each, one-cycle completion pulse.
REQ-010 Ports b_cs, b_wr, b_rd, output, 1 each, shared basic-bus chip select and strobes.
REQ-011 Port b_addr, output, 21, shared bus word address.
REQ-012 Port b_wr_data, output, 32, shared bus write data.
REQ-013 Port b_rd_data, input, 32, shared bus read data.

Function
REQ-014 FSM states: IDLE, ACCESS, WAIT, DONE; state and every output register are clocked by clk and cleared by reset.
REQ-015 IDLE: with no request pending, remain in IDLE; with any mn_req high, grant one master, latch its wr, rd, addr and wr_data, and go to ACCESS.
REQ-016 Arbitration is round-robin: a single requester wins; on simultaneous requests the master not served last wins; the last-served pointer resets to master 1, so master 0 wins the first tie.
REQ-017 ACCESS lasts exactly 1 cycle and drives the following from the latched values: b_cs=1, b_addr, b_wr_data, b_wr=latched wr, b_rd=latched rd && !latched wr.
REQ-018 If wr and rd are both high, the transaction is a write and rd is ignored.
REQ-019 If neither wr nor rd is high, the transaction still runs with no strobe and still completes with ready.
REQ-020 WAIT lasts RD_LAT cycles, counted by a 4-bit counter.
REQ-021 During WAIT, b_cs stays high, b_addr stays stable, and both strobes are low.
REQ-022 In the last WAIT cycle, b_rd_data is captured into the granted master's mn_rd_data; the capture happens for reads only, and mn_rd_data otherwise holds its value.
REQ-023 DONE lasts 1 cycle: it asserts the granted master's mn_ready, updates the last-served pointer, and returns to IDLE.
REQ-024 The non-granted master's ready stays low throughout the transaction.
REQ-025 Latency: a request sampled in IDLE at cycle T gives ACCESS at T+1, DONE (ready high, data valid) at T+2+RD_LAT, and IDLE at T+3+RD_LAT.
REQ-026 mn_req is ignored outside IDLE.
REQ-027 A master that drops req mid-transaction does not abort it; the transaction completes and ready still pulses.
REQ-028 A req still high in the IDLE cycle after DONE is treated as a new transaction.
REQ-029 Strobes are high only in ACCESS, so each transaction produces at most one b_wr or b_rd pulse.
REQ-030 b_cs is high only in ACCESS and WAIT.
REQ-031 m0_ready and m1_ready are never high together.
REQ-032 Outside a grant, b_addr and b_wr_data hold their last values.

Reset
REQ-033 On reset assertion (asynchronous) the block enters IDLE and forces to 0: b_cs, b_wr, b_rd, b_addr, b_wr_data, m0_rd_data, m1_rd_data, m0_ready, m1_ready, and the WAIT counter.
REQ-034 On reset assertion the last-served pointer is set to master 1.
REQ-035 Reset asserted mid-transaction aborts it with no ready pulse; no strobe is issued in the cycle after reset deasserts.

Verification
REQ-036 Single read: RD_LAT=1; m0 reads addr 0x00010 with b_rd_data=0xDEADBEEF -> b_rd high 1 cycle at T+1, m0_rd_data=0xDEADBEEF and m0_ready high at T+3.
REQ-037 Single write: m1 writes 0x12345678 to addr 0x1FFFFF -> b_wr=1, b_cs=1, b_addr=0x1FFFFF, b_wr_data=0x12345678 for 1 cycle; m1_ready at T+3; m1_rd_data unchanged.
REQ-038 Tie and round-robin: m0 and m1 request together at T -> m0 is served first, then m1 is granted at T+5; each ready pulses exactly once.
REQ-039 Wait states: RD_LAT=4 read -> b_cs high 5 cycles, one b_rd pulse, ready at T+6, data sampled in cycle T+5.
REQ-040 Both qualifiers: wr=rd=1 -> b_wr pulses and b_rd stays 0; neither qualifier -> no strobe and ready still pulses.
REQ-041 Reset in WAIT: assert reset during WAIT -> all outputs are 0 immediately, no ready pulse, and the next tie is won by m0.
